icmp_echo_tx: RTL and testbench
===============================

Name: icmp_echo_tx

Overview:
- Parametrised ICMP echo-reply transmitter.
- Accepts a reply request (id, seq, payload length), buffers the echo payload, and computes the ICMP checksum over header plus payload on the fly.
- Requests the Ethernet/IP header from the header builder, then streams ICMP header, payload and minimum-frame padding as an AXI-Stream-style byte stream with backpressure.
- Sits between the ICMP request parser and the TX byte mux.

Parameters:
- MAX_PAYLOAD, 64: payload buffer depth in bytes; must be at least 1.
- MIN_ICMP_BYTES, 26: minimum ICMP bytes on the wire (46 − 20 IP); zero padding is added up to this count.
- ICMP_TYPE, 8'h00: type byte emitted; code is always 8'h00.

Ports:
- aclk  in  1  clock.
- areset  in  1  synchronous, active-high reset.
- req_valid  in  1  reply request.
- req_ready  out  1  high only in IDLE.
- req_id  in  16  echo identifier.
- req_seq  in  16  echo sequence number.
- req_len  in  16  payload byte count.
- pl_wr_en  in  1  payload byte strobe.
- pl_wr_data  in  8  payload byte.
- eth_header_ip_icmp_tx_start  out  1  header-builder start level.
- icmp_len  out  16  8 + latched length; stable from WAIT_IP until DONE.
- ip_header_tx_done  in  1  header builder finished.
- m_tdata  out  8  output byte.
- m_tvalid  out  1  output valid.
- m_tready  in  1  downstream ready.
- m_tlast  out  1  last byte of the ICMP section.
- icmp_tx_done  out  1  one-cycle completion pulse.
- len_err  out  1  one-cycle pulse: req_len exceeded MAX_PAYLOAD.

Behaviour:
- Reset (areset high at a clock edge):
  - All outputs 0, except req_ready = 1.
  - FSM returns to IDLE; checksum and counters clear.
  - Mid-frame reset abandons the frame without emitting m_tlast.
- IDLE: on req_valid && req_ready, latch id, seq and len_eff = min(req_len, MAX_PAYLOAD). Pulse len_err the next cycle if clamped. Go to LOAD, or to CSUM if len_eff = 0.
- LOAD:
  - Each pl_wr_en writes pl_wr_data to buffer[wr_cnt] and increments wr_cnt.
  - Bytes at even index are the high byte of a 16-bit word; odd-index bytes are the low byte.
  - Accumulator adds each completed word; on an odd final byte it adds {byte, 8'h00}.
  - After wr_cnt == len_eff, go to CSUM.
  - pl_wr_en outside LOAD is ignored.
- Checksum arithmetic:
  - Accumulator is 17 bits; every addition folds the end-around carry in the same cycle, so the 16-bit value is always valid.
  - Seed is {ICMP_TYPE, 8'h00}.
- CSUM (2 cycles): add id, then seq. Register checksum = ~acc. Go to WAIT_IP and assert eth_header_ip_icmp_tx_start.
- WAIT_IP: on ip_header_tx_done, deassert start and go to HDR.
- HDR: emit 8 bytes in order: type, 00, cksum[15:8], cksum[7:0], id[15:8], id[7:0], seq[15:8], seq[7:0].
- PAYLOAD: emit len_eff buffered bytes in write order.
- PAD: emit 00 bytes until the total emitted count = max(8 + len_eff, MIN_ICMP_BYTES).
- Stream rules:
  - m_tvalid stays high continuously from HDR through the final byte.
  - A byte transfers on m_tvalid && m_tready; m_tdata is held stable while m_tready is low.
  - Byte counter advances only on a transfer.
  - m_tlast is high on the final byte only.
  - First byte appears the cycle after ip_header_tx_done.
- DONE: pulse icmp_tx_done for 1 cycle, return to IDLE (req_ready high the next cycle).
- Buffer: single-port synchronous RAM, read address pre-fetched one byte ahead so zero-bubble streaming holds under continuous m_tready.
- Simultaneous events:
  - req_valid during a frame is not accepted.
  - ip_header_tx_done outside WAIT_IP is ignored.

Decomposition:
- Package icmp_pkg holds:
  - ICMP type/code constants (echo reply 0, echo request 8).
  - ICMP_HDR_BYTES = 8 and MIN_ICMP_BYTES default.
  - FSM typedef (IDLE, LOAD, CSUM, WAIT_IP, HDR, PAYLOAD, PAD, DONE).
  - Ones-complement add function (17-bit fold).
- One sub-module, icmp_csum_acc: byte-in/word-pair accumulator with seed, add16 and finalise. It is reused later by icmp_rx verification.

Test Plan:
- id=0x1234, seq=0x0001, len=0 → bytes 00 00 ED CA 12 34 00 01 then 18×00; m_tlast on byte 26; icmp_len=8; one icmp_tx_done pulse.
- Same id/seq, len=3, payload AA BB CC → checksum 0x770E; 8 header bytes, AA BB CC, 15×00; m_tlast on byte 26.
- len=32, payload 0x00..0x1F → 40 bytes, no padding, m_tlast on byte 40; checksum matches the reference model.
- len=40 with MAX_PAYLOAD=32 → len_err pulse, len_eff=32, icmp_len=40; bytes 33–40 on pl_wr_en are ignored.
- Random m_tready (50% low) during the len=32 frame → byte sequence identical to the back-pressure-free run; m_tdata stable while stalled.
- areset high for 1 cycle mid-PAYLOAD → all outputs 0, req_ready=1 next cycle; a following len=0 request produces a correct frame.

Source files
------------

// File: rtl/icmp_pkg.sv
// Shared ICMP constants, FSM state type and ones-complement helper
// used by the echo-reply transmitter and its checksum accumulator.
package icmp_pkg;

    localparam logic [7:0] ICMP_TYPE_ECHO_REPLY = 8'h00;
    localparam logic [7:0] ICMP_TYPE_ECHO_REQ   = 8'h08;
    localparam logic [7:0] ICMP_CODE            = 8'h00;

    localparam int ICMP_HDR_BYTES = 8;
    localparam int ICMP_MIN_BYTES = 26;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CSUM,
        WAIT_IP,
        HDR,
        PAYLOAD,
        PAD,
        DONE
    } icmp_state_t;

    // 17-bit add with end-around carry folded back in
    function automatic logic [15:0] ones_add(
        input logic [15:0] a,
        input logic [15:0] b
    );
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

endpackage

// File: rtl/icmp_csum_acc.sv
// Ones-complement checksum accumulator: bytes pair into 16-bit words,
// plus direct 16-bit adds; cksum is the finalised (inverted) sum.
module icmp_csum_acc
    import icmp_pkg::*;
(
    input  logic        aclk,
    input  logic        areset,
    input  logic        init,
    input  logic [15:0] seed,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    input  logic        byte_last,
    input  logic        add_en,
    input  logic [15:0] add_data,
    output logic [15:0] cksum
);

    logic [15:0] acc;
    logic [7:0]  hi;
    logic        odd;

    always_ff @(posedge aclk) begin
        if (areset) begin
            acc <= 16'h0000;
            hi  <= 8'h00;
            odd <= 1'b0;
        end else if (init) begin
            acc <= seed;
            hi  <= 8'h00;
            odd <= 1'b0;
        end else if (byte_en) begin
            if (odd) begin
                acc <= ones_add(acc, {hi, byte_data});
                odd <= 1'b0;
            end else if (byte_last) begin
                // trailing odd byte is padded with a zero low byte
                acc <= ones_add(acc, {byte_data, 8'h00});
            end else begin
                hi  <= byte_data;
                odd <= 1'b1;
            end
        end else if (add_en) begin
            acc <= ones_add(acc, add_data);
        end
    end

    assign cksum = ~acc;

endmodule

// File: rtl/icmp_echo_tx.sv
// ICMP echo-reply transmitter: buffers payload, checksums on the fly,
// then streams header, payload and minimum-frame padding bytewise.
module icmp_echo_tx
    import icmp_pkg::*;
#(
    parameter int         MAX_PAYLOAD    = 64,
    parameter int         MIN_ICMP_BYTES = ICMP_MIN_BYTES,
    parameter logic [7:0] ICMP_TYPE      = ICMP_TYPE_ECHO_REPLY
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_id,
    input  logic [15:0] req_seq,
    input  logic [15:0] req_len,
    input  logic        pl_wr_en,
    input  logic [7:0]  pl_wr_data,
    output logic        eth_header_ip_icmp_tx_start,
    output logic [15:0] icmp_len,
    input  logic        ip_header_tx_done,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        icmp_tx_done,
    output logic        len_err
);

    localparam int          AW      = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);
    localparam logic [15:0] MIN_LEN = 16'(MIN_ICMP_BYTES);
    localparam logic [15:0] HDR_LEN = 16'(ICMP_HDR_BYTES);

    icmp_state_t state, state_nxt;

    logic [15:0] id_r, seq_r, len_r, tot_r;
    logic [15:0] wr_cnt, byte_cnt, pidx;
    logic [15:0] len_eff, len_hdr, cnt_inc, pidx_nxt, cksum;
    logic        csum_ph, accept, wr_fire, wr_last, xfer;
    logic [7:0]  mem [MAX_PAYLOAD];
    logic [7:0]  rd_data, hdr_byte;
    logic [AW-1:0] ram_addr;

    assign req_ready = (state == IDLE);
    assign m_tvalid  = (state == HDR) || (state == PAYLOAD) || (state == PAD);
    assign accept    = req_valid && req_ready;
    assign len_eff   = (req_len > MAX_LEN) ? MAX_LEN : req_len;
    assign len_hdr   = len_eff + HDR_LEN;
    assign wr_fire   = (state == LOAD) && pl_wr_en;
    assign wr_last   = (wr_cnt + 16'd1) == len_r;
    assign xfer      = m_tvalid && m_tready;
    assign cnt_inc   = byte_cnt + 16'd1;

    // read pointer runs one byte ahead on each payload transfer
    assign pidx_nxt = (xfer && state == PAYLOAD) ? pidx + 16'd1 : pidx;
    assign ram_addr = (state == LOAD) ? wr_cnt[AW-1:0] : pidx_nxt[AW-1:0];

    always_ff @(posedge aclk) begin
        if (wr_fire) mem[ram_addr] <= pl_wr_data;
        rd_data <= mem[ram_addr];
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            id_r     <= 16'h0000;
            seq_r    <= 16'h0000;
            len_r    <= 16'h0000;
            tot_r    <= 16'h0000;
            wr_cnt   <= 16'h0000;
            byte_cnt <= 16'h0000;
            pidx     <= 16'h0000;
            csum_ph  <= 1'b0;
            icmp_len <= 16'h0000;
            len_err  <= 1'b0;
        end else begin
            len_err <= accept && (req_len > MAX_LEN);
            pidx    <= pidx_nxt;
            if (wr_fire) wr_cnt <= wr_cnt + 16'd1;
            if (xfer) byte_cnt <= cnt_inc;
            if (state == CSUM) csum_ph <= ~csum_ph;
            if (accept) begin
                id_r     <= req_id;
                seq_r    <= req_seq;
                len_r    <= len_eff;
                icmp_len <= len_hdr;
                tot_r    <= (len_hdr > MIN_LEN) ? len_hdr : MIN_LEN;
                wr_cnt   <= 16'h0000;
                byte_cnt <= 16'h0000;
                pidx     <= 16'h0000;
                csum_ph  <= 1'b0;
            end
        end
    end

    icmp_csum_acc u_csum (
        .aclk      (aclk),
        .areset    (areset),
        .init      (accept),
        .seed      ({ICMP_TYPE, ICMP_CODE}),
        .byte_en   (wr_fire),
        .byte_data (pl_wr_data),
        .byte_last (wr_last),
        .add_en    (state == CSUM),
        .add_data  (csum_ph ? seq_r : id_r),
        .cksum     (cksum)
    );

    always_comb begin
        hdr_byte = 8'h00;
        unique case (byte_cnt[2:0])
            3'd0: hdr_byte = ICMP_TYPE;
            3'd1: hdr_byte = ICMP_CODE;
            3'd2: hdr_byte = cksum[15:8];
            3'd3: hdr_byte = cksum[7:0];
            3'd4: hdr_byte = id_r[15:8];
            3'd5: hdr_byte = id_r[7:0];
            3'd6: hdr_byte = seq_r[15:8];
            3'd7: hdr_byte = seq_r[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt                   = state;
        m_tdata                     = 8'h00;
        m_tlast                     = 1'b0;
        icmp_tx_done                = 1'b0;
        eth_header_ip_icmp_tx_start = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) state_nxt = (len_eff == 16'd0) ? CSUM : LOAD;
            end
            LOAD: begin
                if (wr_fire && wr_last) state_nxt = CSUM;
            end
            CSUM: begin
                if (csum_ph) state_nxt = WAIT_IP;
            end
            WAIT_IP: begin
                eth_header_ip_icmp_tx_start = 1'b1;
                if (ip_header_tx_done) state_nxt = HDR;
            end
            HDR, PAYLOAD, PAD: begin
                if (state == HDR)     m_tdata = hdr_byte;
                if (state == PAYLOAD) m_tdata = rd_data;
                m_tlast = (cnt_inc == tot_r);
                if (xfer) begin
                    if (cnt_inc == tot_r)              state_nxt = DONE;
                    else if (cnt_inc < HDR_LEN)         state_nxt = HDR;
                    else if (cnt_inc < HDR_LEN + len_r) state_nxt = PAYLOAD;
                    else                                state_nxt = PAD;
                end
            end
            DONE: begin
                icmp_tx_done = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_icmp_echo_tx.sv
// Scoreboard bench for icmp_echo_tx: expected bytes are queued per
// request and a negedge monitor checks every stream transfer.
module tb_icmp_echo_tx;

    localparam int         MAXP   = 32;
    localparam int         MINB   = 26;
    localparam logic [7:0] ICMP_T = 8'h00;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_id = 16'h0;
    logic [15:0] req_seq = 16'h0;
    logic [15:0] req_len = 16'h0;
    logic        pl_wr_en = 1'b0;
    logic [7:0]  pl_wr_data = 8'h0;
    logic        start;
    logic [15:0] icmp_len;
    logic        ip_done = 1'b0;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;
    logic        icmp_tx_done;
    logic        len_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0] exp_q[$];
    logic [7:0] pl [64];
    bit         rand_tready = 1'b0;

    always #5 aclk = ~aclk;

    icmp_echo_tx #(
        .MAX_PAYLOAD    (MAXP),
        .MIN_ICMP_BYTES (MINB),
        .ICMP_TYPE      (ICMP_T)
    ) dut (
        .aclk                        (aclk),
        .areset                      (areset),
        .req_valid                   (req_valid),
        .req_ready                   (req_ready),
        .req_id                      (req_id),
        .req_seq                     (req_seq),
        .req_len                     (req_len),
        .pl_wr_en                    (pl_wr_en),
        .pl_wr_data                  (pl_wr_data),
        .eth_header_ip_icmp_tx_start (start),
        .icmp_len                    (icmp_len),
        .ip_header_tx_done           (ip_done),
        .m_tdata                     (m_tdata),
        .m_tvalid                    (m_tvalid),
        .m_tready                    (m_tready),
        .m_tlast                     (m_tlast),
        .icmp_tx_done                (icmp_tx_done),
        .len_err                     (len_err)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [15:0] ref_cksum(input logic [15:0] id,
                                              input logic [15:0] seq,
                                              input int n);
        int unsigned s;
        logic [7:0]  lo;
        s = {16'd0, ICMP_T, 8'h00};
        for (int i = 0; i < n; i += 2) begin
            lo = (i + 1 < n) ? pl[i+1] : 8'h00;
            s += {16'd0, pl[i], lo};
        end
        s += {16'd0, id};
        s += {16'd0, seq};
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        return ~s[15:0];
    endfunction

    initial forever begin
        @(posedge aclk);
        #1;
        m_tready = rand_tready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    bit         stalled = 1'b0;
    bit         in_frame = 1'b0;
    logic [7:0] held = 8'h0;
    logic [8:0] e;

    always @(negedge aclk) begin
        if (areset) begin
            stalled  = 1'b0;
            in_frame = 1'b0;
        end else begin
            if (stalled && m_tvalid) check("stall_hold", m_tdata, held);
            if (in_frame) check("tvalid_cont", m_tvalid, 1);
            stalled = m_tvalid && !m_tready;
            held    = m_tdata;
            if (m_tvalid) in_frame = 1'b1;
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %0h expected none", m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("byte_data", m_tdata, e[7:0]);
                    check("byte_last", m_tlast, e[8]);
                    if (e[8]) in_frame = 1'b0;
                end
            end
        end
    end

    task automatic run_frame(input logic [15:0] id, input logic [15:0] seq,
                             input logic [15:0] len, input int nwr,
                             input bit use_ref, input logic [15:0] hand_cks,
                             input int abort_at);
        int         leff, tot, t;
        logic [15:0] cks;
        logic [7:0] hdr [8];
        logic [7:0] b;
        leff = (int'(len) > MAXP) ? MAXP : int'(len);
        cks  = use_ref ? ref_cksum(id, seq, leff) : hand_cks;
        hdr[0] = ICMP_T;     hdr[1] = 8'h00;
        hdr[2] = cks[15:8];  hdr[3] = cks[7:0];
        hdr[4] = id[15:8];   hdr[5] = id[7:0];
        hdr[6] = seq[15:8];  hdr[7] = seq[7:0];
        tot = (leff + 8 < MINB) ? MINB : leff + 8;
        for (int k = 0; k < tot; k++) begin
            if (k < 8)             b = hdr[k];
            else if (k < 8 + leff) b = pl[k-8];
            else                   b = 8'h00;
            exp_q.push_back({k == tot - 1, b});
        end
        t = 0;
        while (!req_ready && t < 100) begin tick(); t++; end
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_id    = id;
        req_seq   = seq;
        req_len   = len;
        tick();
        req_valid = 1'b0;
        check("len_err", len_err, 32'(int'(len) > MAXP));
        check("icmp_len_latch", icmp_len, leff + 8);
        for (int i = 0; i < nwr; i++) begin
            pl_wr_en   = 1'b1;
            pl_wr_data = pl[i];
            tick();
        end
        pl_wr_en = 1'b0;
        check("len_err_pulse", len_err, 0);
        t = 0;
        while (!start && t < 100) begin tick(); t++; end
        check("start_seen", start, 1);
        check("icmp_len_wait", icmp_len, leff + 8);
        check("req_ready_busy", req_ready, 0);
        ip_done = 1'b1;
        tick();
        ip_done = 1'b0;
        check("first_valid", m_tvalid, 1);
        check("start_drop", start, 0);
        if (abort_at > 0) begin
            repeat (abort_at) tick();
            areset = 1'b1;
            tick();
            areset = 1'b0;
            check("rst_tvalid", m_tvalid, 0);
            check("rst_tlast", m_tlast, 0);
            check("rst_start", start, 0);
            check("rst_ready", req_ready, 1);
            check("rst_len", icmp_len, 0);
            exp_q.delete();
        end else begin
            t = 0;
            while (!icmp_tx_done && t < 1000) begin tick(); t++; end
            check("done_seen", icmp_tx_done, 1);
            check("queue_empty", exp_q.size(), 0);
            tick();
            check("done_pulse", icmp_tx_done, 0);
            check("req_ready_after", req_ready, 1);
        end
    endtask

    initial begin
        repeat (3) tick();
        areset = 1'b0;
        check("reset_ready", req_ready, 1);
        check("reset_tvalid", m_tvalid, 0);
        check("reset_start", start, 0);
        check("reset_len", icmp_len, 0);
        check("reset_done", icmp_tx_done, 0);
        check("reset_len_err", len_err, 0);

        ip_done = 1'b1;
        tick();
        ip_done = 1'b0;
        tick();
        check("stray_ipdone_tvalid", m_tvalid, 0);
        check("stray_ipdone_ready", req_ready, 1);

        run_frame(16'h1234, 16'h0001, 16'd0, 0, 1'b0, 16'hEDCA, 0);

        pl[0] = 8'hAA; pl[1] = 8'hBB; pl[2] = 8'hCC;
        run_frame(16'h1234, 16'h0001, 16'd3, 3, 1'b0, 16'h770E, 0);

        for (int i = 0; i < 64; i++) pl[i] = 8'(i);
        run_frame(16'hBEEF, 16'h0102, 16'd32, 32, 1'b1, 16'h0, 0);

        for (int i = 32; i < 40; i++) pl[i] = 8'hF0 | 8'(i);
        run_frame(16'h0A0B, 16'h0C0D, 16'd40, 40, 1'b1, 16'h0, 0);

        for (int i = 0; i < 64; i++) pl[i] = 8'(i);
        rand_tready = 1'b1;
        run_frame(16'hBEEF, 16'h0102, 16'd32, 32, 1'b1, 16'h0, 0);
        rand_tready = 1'b0;
        tick();

        run_frame(16'h5555, 16'h0007, 16'd32, 32, 1'b1, 16'h0, 12);
        run_frame(16'h1234, 16'h0001, 16'd0, 0, 1'b0, 16'hEDCA, 0);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
